// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store adapter onto a 4-byte big-endian memory port
// Build option: define LSU_ALIGN_CHECK_EN to fault misaligned halfword/word requests.
module load_store_unit #(
  parameter int addresswidth = 28
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [1:0]              i_size,
  input  logic                    i_sign_ext,
  input  logic [addresswidth-1:0] i_addr,
  input  logic [31:0]             i_wdata,
  output logic                    o_ready,
  output logic                    o_resp_valid,
  output logic [31:0]             o_rdata,
  output logic                    o_fault,
  output logic [addresswidth-1:0] o_mem_address,
  output logic                    o_mem_writeEnable,
  output logic [31:0]             o_mem_dataIn,
  input  logic [31:0]             i_mem_dataOut
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                  r_state;

  // Request registers: everything after acceptance works from these copies.
  logic                    r_we;
  logic [1:0]              r_size;
  logic                    r_sign_ext;
  logic [addresswidth-1:0] r_addr;
  logic [31:0]             r_wdata;

  // Registered outputs.
  logic                    r_ready;
  logic                    r_resp_valid;
  logic [31:0]             r_rdata;
  logic                    r_fault;
  logic                    r_mem_we;
  logic [31:0]             r_merge;

  logic                    w_req_fault;
  logic [31:0]             w_load_value;
  logic [31:0]             w_merge_value;

  // Decide whether the incoming request is rejected outright.
  always_comb begin
    w_req_fault = (i_size == SIZE_RSVD);
`ifdef LSU_ALIGN_CHECK_EN
    if ((i_size == SIZE_HALF) && i_addr[0])
      w_req_fault = 1'b1;
    if ((i_size == SIZE_WORD) && (i_addr[1:0] != 2'b00))
      w_req_fault = 1'b1;
`endif
  end

  // Extract and extend the addressed bytes; the memory presents addr..addr+3 with addr in [31:24].
  always_comb begin
    w_load_value = 32'd0;
    if (!r_we) begin
      case (r_size)
        SIZE_BYTE: w_load_value = {{24{r_sign_ext & i_mem_dataOut[31]}}, i_mem_dataOut[31:24]};
        SIZE_HALF: w_load_value = {{16{r_sign_ext & i_mem_dataOut[31]}}, i_mem_dataOut[31:16]};
        default:   w_load_value = i_mem_dataOut;
      endcase
    end
  end

  // Overlay the store bytes onto the word read back, so the full 4-byte write preserves neighbours.
  always_comb begin
    case (r_size)
      SIZE_BYTE: w_merge_value = {r_wdata[7:0], i_mem_dataOut[23:0]};
      SIZE_HALF: w_merge_value = {r_wdata[15:0], i_mem_dataOut[15:0]};
      default:   w_merge_value = r_wdata;
    endcase
  end

  // Request FSM with registered handshake and memory-port outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_sign_ext   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_fault      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_merge      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we       <= i_we;
            r_size     <= i_size;
            r_sign_ext <= i_sign_ext;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            r_ready    <= 1'b0;
            r_rdata    <= 32'd0;
            if (w_req_fault) begin
              r_fault      <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (!i_we) begin
              r_state <= S_LOAD;
            end else if (i_size == SIZE_WORD) begin
              // Full-word store needs no read: data is known now.
              r_merge  <= i_wdata;
              r_mem_we <= 1'b1;
              r_state  <= S_WRITE;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          r_rdata      <= w_load_value;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RMW_RD: begin
          r_merge  <= w_merge_value;
          r_mem_we <= 1'b1;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_fault      <= 1'b0;
          r_rdata      <= 32'd0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_fault      <= 1'b0;
          r_mem_we     <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready           = r_ready;
  assign o_resp_valid      = r_resp_valid;
  assign o_rdata           = r_rdata;
  assign o_fault           = r_fault;
  assign o_mem_address     = r_addr;
  assign o_mem_writeEnable = r_mem_we;
  assign o_mem_dataIn      = r_merge;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sx = 1'b0;
  logic [27:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic [27:0] mem_address;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];

  int total = 0;
  int bad = 0;
  int t = 0;
  int m_idle_t = 0;
  int m_resp_t = -1;
  int m_wr_t = -1;
  logic [31:0] m_rdata = '0;
  logic        m_fault = 1'b0;
  logic [27:0] m_addr = '0;
  logic [31:0] m_wr_data = '0;
  bit          acc_flag = 1'b0;
  int          last_resp_t = -1;
  logic [31:0] last_rdata = '0;
  logic        last_fault = 1'b0;
  int          resp_cnt = 0;
  int          we_cnt = 0;

  load_store_unit #(.addresswidth(28)) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_req            (req),
    .i_we             (we),
    .i_size           (size),
    .i_sign_ext       (sx),
    .i_addr           (addr),
    .i_wdata          (wdata),
    .o_ready          (ready),
    .o_resp_valid     (resp_valid),
    .o_rdata          (rdata),
    .o_fault          (fault),
    .o_mem_address    (mem_address),
    .o_mem_writeEnable(mem_we),
    .o_mem_dataIn     (mem_din),
    .i_mem_dataOut    (mem_dout)
  );

  always #5 clk = ~clk;

  // Byte-addressed data memory: combinational 4-byte big-endian read, full 4-byte write.
  always_comb begin
    mem_dout = '0;
    for (int k = 0; k < 4; k++)
      mem_dout[31-8*k -: 8] = mem[8'(mem_address + 28'(k))];
  end

  always @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < 4; k++)
        mem[8'(mem_address + 28'(k))] <= mem_din[31-8*k -: 8];
    if (pl_en)
      for (int k = 0; k < 4; k++)
        mem[8'(pl_addr + 8'(k))] <= pl_data[31-8*k -: 8];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0d)", nm, act, exp, t);
    end
  endtask

  function automatic bit model_fault(input logic [1:0] sz, input logic [27:0] a);
    return (sz == 2'd3) ||
           (ALIGN_EN && (((sz == 2'd1) && (a % 2 != 0)) || ((sz == 2'd2) && (a % 4 != 0))));
  endfunction

  // Reference model and per-cycle comparison, evaluated mid-cycle.
  task automatic check_cycle();
    bit         exp_ready;
    logic [7:0] b [4];
    int         nb;
    longint     v;
    acc_flag = 1'b0;
    if (!rst_n) begin
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_din", mem_din, 32'd0);
      check("rst_mem_addr", 32'(mem_address), 32'd0);
      m_idle_t = t;
      m_resp_t = -1;
      m_wr_t   = -1;
    end else begin
      exp_ready = (t >= m_idle_t);
      check("ready", 32'(ready), 32'(exp_ready));
      check("resp_valid", 32'(resp_valid), 32'(t == m_resp_t));
      if (t == m_resp_t) begin
        check("rdata", rdata, m_rdata);
        check("fault", 32'(fault), 32'(m_fault));
      end
      check("mem_we", 32'(mem_we), 32'(t == m_wr_t));
      if (t == m_wr_t) begin
        check("mem_din", mem_din, m_wr_data);
        for (int k = 0; k < 4; k++)
          ref_mem[8'(m_addr + 28'(k))] = m_wr_data[31-8*k -: 8];
      end
      if (!exp_ready)
        check("mem_address", 32'(mem_address), 32'(m_addr));
      if (resp_valid) begin
        last_resp_t = t;
        last_rdata  = rdata;
        last_fault  = fault;
        resp_cnt++;
      end
      if (mem_we)
        we_cnt++;
      if (exp_ready && req) begin
        acc_flag = 1'b1;
        m_addr   = addr;
        for (int k = 0; k < 4; k++)
          b[k] = ref_mem[8'(addr + 28'(k))];
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        m_rdata = '0;
        m_fault = 1'b0;
        m_wr_t  = -1;
        if (model_fault(size, addr)) begin
          m_fault  = 1'b1;
          m_resp_t = t + 1;
        end else if (!we) begin
          v = 0;
          for (int k = 0; k < nb; k++)
            v = v * 256 + longint'(b[k]);
          if (sx && nb < 4 && v >= (longint'(1) << (8*nb-1)))
            v = v - (longint'(1) << (8*nb));
          m_rdata  = 32'(v);
          m_resp_t = t + 2;
        end else begin
          for (int k = 0; k < nb; k++)
            b[k] = 8'(wdata >> (8*(nb-1-k)));
          m_wr_data = {b[0], b[1], b[2], b[3]};
          m_wr_t    = (nb == 4) ? t + 1 : t + 2;
          m_resp_t  = m_wr_t + 1;
        end
        m_idle_t = m_resp_t + 1;
      end
    end
    if (pl_en)
      for (int k = 0; k < 4; k++)
        ref_mem[8'(pl_addr + 8'(k))] = pl_data[31-8*k -: 8];
    t++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic run_req(input bit we_i, input logic [1:0] sz_i, input bit sx_i,
                         input logic [27:0] a_i, input logic [31:0] wd_i,
                         output logic [31:0] rd_o, output bit f_o, output int lat_o);
    int t_acc;
    t_acc = -1;
    req = 1'b1; we = we_i; size = sz_i; sx = sx_i; addr = a_i; wdata = wd_i;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc_flag) begin
        t_acc = t - 1;
        break;
      end
    end
    req = 1'b0;
    we = 1'($urandom); size = 2'($urandom); sx = 1'($urandom);
    addr = 28'($urandom); wdata = $urandom;
    rd_o = '0; f_o = 1'b0; lat_o = -1;
    check("accepted", 32'(t_acc >= 0), 32'd1);
    if (t_acc < 0) return;
    for (int i = 0; i < 8; i++) begin
      if (last_resp_t > t_acc) break;
      step();
    end
    check("resp_seen", 32'(last_resp_t > t_acc), 32'd1);
    rd_o  = last_rdata;
    f_o   = last_fault;
    lat_o = last_resp_t - t_acc;
  endtask

  initial begin
    logic [31:0] rd;
    bit          f;
    int          lat;
    int          n0;
    int          nmis;
    int          t_acc;

    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++)
      preload(8'(4*i), $urandom);

    // Random traffic, including requests while busy and one mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        req = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      req   = ($urandom_range(0, 2) != 0);
      we    = 1'($urandom);
      size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sx    = 1'($urandom);
      addr  = ($urandom_range(0, 1) == 1) ? 28'(16 + $urandom_range(0, 15))
                                          : 28'(28'hFFFFFFC + 28'($urandom_range(0, 3)));
      wdata = $urandom;
      step();
    end
    req = 1'b0;
    repeat (6) step();
    nmis = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) nmis++;
    check("mem_image_random", 32'(nmis), 32'd0);

    // Loads from a known word.
    preload(8'h10, 32'h80123456);
    run_req(1'b0, 2'd0, 1'b1, 28'h10, 32'h0, rd, f, lat);
    check("lb_sext", rd, 32'hFFFFFF80);
    check("lb_latency", 32'(lat), 32'd2);
    run_req(1'b0, 2'd0, 1'b0, 28'h10, 32'h0, rd, f, lat);
    check("lbu_zext", rd, 32'h00000080);
    run_req(1'b0, 2'd1, 1'b1, 28'h10, 32'h0, rd, f, lat);
    check("lh_sext", rd, 32'hFFFF8012);
    run_req(1'b0, 2'd2, 1'b0, 28'h10, 32'h0, rd, f, lat);
    check("lw", rd, 32'h80123456);

    // Word store then read back.
    n0 = we_cnt;
    run_req(1'b1, 2'd2, 1'b0, 28'h20, 32'hDEADBEEF, rd, f, lat);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_we_pulses", 32'(we_cnt - n0), 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 28'h20, 32'h0, rd, f, lat);
    check("sw_readback", rd, 32'hDEADBEEF);

    // Byte store read-modify-write.
    preload(8'h30, 32'h11223344);
    run_req(1'b1, 2'd0, 1'b0, 28'h30, 32'h000000AA, rd, f, lat);
    check("sb_latency", 32'(lat), 32'd3);
    check("sb_mem", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'hAA223344);

    // Misaligned halfword store.
    preload(8'h40, 32'h11223344);
    run_req(1'b1, 2'd1, 1'b0, 28'h41, 32'h0000BEEF, rd, f, lat);
    check("sh41_fault", 32'(f), ALIGN_EN ? 32'd1 : 32'd0);
    check("sh41_latency", 32'(lat), ALIGN_EN ? 32'd1 : 32'd3);
    check("sh41_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]},
          ALIGN_EN ? 32'h11223344 : 32'h11BEEF44);

    // Reserved size faults for loads and stores.
    run_req(1'b0, 2'd3, 1'b1, 28'h10, 32'h0, rd, f, lat);
    check("rsvd_ld_fault", 32'(f), 32'd1);
    check("rsvd_ld_rdata", rd, 32'd0);
    check("rsvd_ld_latency", 32'(lat), 32'd1);
    n0 = we_cnt;
    run_req(1'b1, 2'd3, 1'b0, 28'h10, 32'h55667788, rd, f, lat);
    check("rsvd_st_fault", 32'(f), 32'd1);
    check("rsvd_st_no_write", 32'(we_cnt - n0), 32'd0);
    check("rsvd_st_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'h80123456);

    // Reset during the read phase of a byte store aborts it silently.
    preload(8'h50, 32'h01020304);
    req = 1'b1; we = 1'b1; size = 2'd0; sx = 1'b0; addr = 28'h50; wdata = 32'h000000CC;
    t_acc = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc_flag) begin
        t_acc = t - 1;
        break;
      end
    end
    check("abort_accepted", 32'(t_acc >= 0), 32'd1);
    req = 1'b0;
    n0 = resp_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_we", 32'(mem_we), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("abort_no_resp", 32'(resp_cnt - n0), 32'd0);
    check("abort_mem", {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]}, 32'h01020304);

    nmis = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) nmis++;
    check("mem_image_final", 32'(nmis), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU datapath and `datamemory` and turns CPU load/store requests of byte, halfword or word size into accesses on the memory's 4-byte, big-endian port. Loads are extracted and sign- or zero-extended. Sub-word stores run as a read-modify-write, because the memory always writes all four bytes at `address..address+3`. The CPU side uses a request/ready handshake with a single-cycle response pulse.

## Interface
- `addresswidth`, 28, byte-address width; must match `datamemory`.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 1: request valid; accepted when `req && ready`.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `sign_ext` input 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `addr` input `addresswidth`: byte address.
- `wdata` input 32: store data, right-justified.
- `ready` output 1: unit idle and able to accept a request.
- `resp_valid` output 1: one-cycle pulse marking completion.
- `rdata` output 32: load result, valid while `resp_valid`; 0 for stores and faults.
- `fault` output 1: valid while `resp_valid`; the request was rejected with no memory write.
- `mem_address` output `addresswidth`: drives `datamemory.address`.
- `mem_writeEnable` output 1: drives `datamemory.writeEnable`.
- `mem_dataIn` output 32: drives `datamemory.dataIn`.
- `mem_dataOut` input 32: from `datamemory.dataOut`, combinational bytes at `address..address+3`.

## Operation
- On acceptance, latch `we`, `size`, `sign_ext`, `addr` and `wdata` into request registers. All later states use only the latched values.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - IDLE, accepted load → LOAD.
  - IDLE, accepted word store → WRITE.
  - IDLE, accepted byte or halfword store → RMW_RD.
  - IDLE, accepted faulting request → RESP.
  - LOAD → RESP; RMW_RD → WRITE; WRITE → RESP; RESP → IDLE.
- `ready` = 1 only in IDLE.
- `resp_valid` = 1 only in RESP.
- `mem_address` = latched address in every state.
- `mem_writeEnable` = 1 only in WRITE.
- LOAD captures `mem_dataOut` and extracts:
  - byte: `mem_dataOut[31:24]`
  - halfword: `mem_dataOut[31:16]`
  - word: `mem_dataOut`
  - Sub-word results are extended to 32 bits per `sign_ext`.
- RMW_RD captures `mem_dataOut` into a merge register `W`. WRITE then drives:
  - byte: `{wdata[7:0], W[23:0]}`
  - halfword: `{wdata[15:0], W[15:0]}`
  - word: `wdata`
- Reserved `size` (11) always faults, with or without the alignment check.
- Address wrap: `addr + k` wraps modulo 2^`addresswidth`, matching `datamemory`. No special handling is required.

## Timing
- Reset values: state IDLE, `ready` = 1, `resp_valid` = 0, `fault` = 0, `rdata` = 0, `mem_writeEnable` = 0, `mem_dataIn` = 0, request registers 0.
- Request accepted at edge N:
  - load: `resp_valid` in cycle N+2
  - word store: write at edge N+2 (WRITE in cycle N+1); `resp_valid` in cycle N+2
  - sub-word store: RMW_RD in cycle N+1, WRITE in cycle N+2; `resp_valid` in cycle N+3
  - fault: `resp_valid` and `fault` in cycle N+1
- Next acceptance is possible at the edge ending the RESP cycle +1, i.e. once back in IDLE. `req` outside IDLE is ignored and is not queued.
- There is no response backpressure; the `resp_valid` pulse is exactly one cycle.
- Reset asserted mid-operation: FSM returns to IDLE immediately and `mem_writeEnable` drops asynchronously. A write whose WRITE edge has not yet occurred is never performed. No response is issued for the aborted request.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - halfword with `addr[0]` ≠ 0 → fault
  - word with `addr[1:0]` ≠ 0 → fault
- Undefined: misaligned addresses are performed as-is. This is legal because the memory port is byte-addressed. Only reserved `size` faults.

## Test plan
- Reset, then preload mem[0x10..0x13] = 80 12 34 56:
  - byte load 0x10, `sign_ext` = 1 → `rdata` 0xFFFFFF80
  - byte load 0x10, `sign_ext` = 0 → `rdata` 0x00000080
  - `resp_valid` exactly 2 cycles after acceptance
- Word store 0xDEADBEEF to 0x20 → exactly one `mem_writeEnable` pulse; a following word load of 0x20 returns 0xDEADBEEF.
- Preload 0x30..0x33 = 11 22 33 44, then byte store `wdata` 0x000000AA to 0x30:
  - memory becomes AA 22 33 44
  - `resp_valid` 3 cycles after acceptance
- With `LSU_ALIGN_CHECK_EN`, halfword store to 0x41 → `fault` = 1 at N+1, no write, memory unchanged. Without the macro, the same store writes bytes 0x41..0x42.
- `size` = 11 → fault in both builds.
- Assert `reset_n` low during the WRITE-pending RMW_RD cycle of a byte store → `ready` = 1 immediately, target bytes unchanged, no `resp_valid`.
